// File: rtl/id_state_if.sv
// Decode-stage bus: fetch/WB inputs into id_state and the registered EX-facing outputs.
// The master modport drives the stage; the slave modport is the stage itself.
interface id_state_if;
  logic [15:0] inst;
  logic        inst_valid;
  logic        hold;
  logic        flush;
  logic [15:0] fwddata;
  logic        wb_we;
  logic [2:0]  wb_rd;
  logic [15:0] wb_data;
  logic [15:0] areg;
  logic [15:0] breg;
  logic [2:0]  com_id;
  logic [2:0]  rd_id;
  logic        rwe_id;
  logic        ld_op_id;
  logic        st_op_id;
  logic        stall_req;

  modport master (
    output inst, inst_valid, hold, flush, fwddata, wb_we, wb_rd, wb_data,
    input  areg, breg, com_id, rd_id, rwe_id, ld_op_id, st_op_id, stall_req
  );

  modport slave (
    input  inst, inst_valid, hold, flush, fwddata, wb_we, wb_rd, wb_data,
    output areg, breg, com_id, rd_id, rwe_id, ld_op_id, st_op_id, stall_req
  );
endinterface

// File: rtl/id_state.sv
// Decode/register-read stage: 8x16 register file, EX forwarding and WB bypass.
// Define ID_FWD_EN to forward fwddata from EX; otherwise EX hazards stall one cycle.
module id_state #(
  parameter logic [2:0] COM_PASSB = 3'b111,
  parameter int         NREG      = 8
) (
  input logic       clk,
  input logic       rst_n,
  id_state_if.slave bus
);
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    CLS_ALU = 2'b00,
    CLS_LD  = 2'b01,
    CLS_ST  = 2'b10,
    CLS_LI  = 2'b11
  } cls_t;

  function automatic logic signed [DATA_W-1:0] sext_imm(input logic signed [7:0] imm);
    logic signed [DATA_W-1:0] wide;
    wide = imm;
    return wide;
  endfunction

  logic [DATA_W-1:0] rf [NREG];

  logic [DATA_W-1:0] areg_p0, breg_p0;
  logic [2:0]        com_p0, rd_p0;
  logic              rwe_p0, ld_p0, st_p0;

  cls_t              cls;
  logic [2:0]        rd, rs, rt;
  logic [DATA_W-1:0] opnd_rs, opnd_rt;
  logic              uses_rs, uses_rt, stall;
  logic [DATA_W-1:0] dec_a, dec_b;
  logic [2:0]        dec_com;
  logic              dec_rwe, dec_ld, dec_st;

  assign cls = cls_t'(bus.inst[15:14]);
  assign rd  = bus.inst[10:8];
  assign rs  = bus.inst[7:5];
  assign rt  = bus.inst[4:2];

  // Operand read: EX forward beats WB bypass beats the register file.
  always_comb begin
    opnd_rs = rf[rs];
    if (bus.wb_we && bus.wb_rd == rs) opnd_rs = bus.wb_data;
`ifdef ID_FWD_EN
    if (rwe_p0 && rd_p0 == rs) opnd_rs = bus.fwddata;
`endif
  end

  always_comb begin
    opnd_rt = rf[rt];
    if (bus.wb_we && bus.wb_rd == rt) opnd_rt = bus.wb_data;
`ifdef ID_FWD_EN
    if (rwe_p0 && rd_p0 == rt) opnd_rt = bus.fwddata;
`endif
  end

  assign uses_rs = (cls != CLS_LI);
  assign uses_rt = (cls == CLS_ALU) || (cls == CLS_ST);

`ifdef ID_FWD_EN
  assign stall = 1'b0;
`else
  wire unused_fwddata = ^bus.fwddata;
  assign stall = bus.inst_valid && !bus.hold && rwe_p0 &&
                 ((uses_rs && rd_p0 == rs) || (uses_rt && rd_p0 == rt));
`endif

  always_comb begin
    dec_a   = '0;
    dec_b   = '0;
    dec_com = 3'b000;
    dec_rwe = 1'b0;
    dec_ld  = 1'b0;
    dec_st  = 1'b0;
    case (cls)
      CLS_ALU: begin
        dec_a   = opnd_rs;
        dec_b   = opnd_rt;
        dec_com = bus.inst[13:11];
        dec_rwe = 1'b1;
      end
      CLS_LD: begin
        dec_b   = opnd_rs;
        dec_com = COM_PASSB;
        dec_rwe = 1'b1;
        dec_ld  = 1'b1;
      end
      CLS_ST: begin
        dec_a  = opnd_rt;
        dec_b  = opnd_rs;
        dec_st = 1'b1;
      end
      CLS_LI: begin
        dec_b   = sext_imm(bus.inst[7:0]);
        dec_com = COM_PASSB;
        dec_rwe = 1'b1;
      end
      default: ;
    endcase
  end

  // ID -> EX boundary; the register file shares this clock and reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf      <= '{default: '0};
      areg_p0 <= '0;
      breg_p0 <= '0;
      com_p0  <= 3'b000;
      rd_p0   <= 3'b000;
      rwe_p0  <= 1'b0;
      ld_p0   <= 1'b0;
      st_p0   <= 1'b0;
    end else begin
      if (bus.wb_we) rf[bus.wb_rd] <= bus.wb_data;
      if (bus.flush || (!bus.hold && (!bus.inst_valid || stall))) begin
        areg_p0 <= '0;
        breg_p0 <= '0;
        com_p0  <= 3'b000;
        rd_p0   <= 3'b000;
        rwe_p0  <= 1'b0;
        ld_p0   <= 1'b0;
        st_p0   <= 1'b0;
      end else if (!bus.hold) begin
        areg_p0 <= dec_a;
        breg_p0 <= dec_b;
        com_p0  <= dec_com;
        rd_p0   <= rd;
        rwe_p0  <= dec_rwe;
        ld_p0   <= dec_ld;
        st_p0   <= dec_st;
      end
    end
  end

  assign bus.areg      = areg_p0;
  assign bus.breg      = breg_p0;
  assign bus.com_id    = com_p0;
  assign bus.rd_id     = rd_p0;
  assign bus.rwe_id    = rwe_p0;
  assign bus.ld_op_id  = ld_p0;
  assign bus.st_op_id  = st_p0;
  assign bus.stall_req = stall;
endmodule
